// File: rtl/serial_tx.sv
// 8N1 serial transmitter: loads a byte on an accepted strobe and shifts it out LSB first,
// with bit timing derived from a 16x sample-tick divider shared in spirit with the receiver.
module serial_tx #(
    parameter int TICKS_PER_SAMPLE = 326,
    parameter int OVERSAMPLE       = 16,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  transmit_en,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  char_sent
);

    localparam int DIV_W = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
    localparam int BSC_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SAMPLE - 1);
    localparam logic [BSC_W-1:0] BSC_LAST = BSC_W'(OVERSAMPLE - 1);
    localparam logic [BIC_W-1:0] BIC_LAST = BIC_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                r_state, w_state;
    logic [DIV_W-1:0]      r_div, w_div;
    logic [BSC_W-1:0]      r_bsc, w_bsc;
    logic [BIC_W-1:0]      r_bic, w_bic;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic                  r_serial_out, w_serial_out;
    logic                  r_busy, w_busy;
    logic                  r_char_sent, w_char_sent;
    logic                  w_tick;
    logic                  w_bit_end;

    // Divider only runs while a frame is in flight, so the start bit is always full length.
    assign w_tick    = (r_state != IDLE) && (r_div == DIV_LAST);
    assign w_bit_end = w_tick && (r_bsc == BSC_LAST);

    always_comb begin
        // NOTE: every next-value signal gets a default first, so no path can infer a latch.
        w_state      = r_state;
        w_div        = r_div;
        w_bsc        = r_bsc;
        w_bic        = r_bic;
        w_shift      = r_shift;
        w_serial_out = r_serial_out;
        w_busy       = r_busy;
        w_char_sent  = 1'b0;

        if (r_state == IDLE || w_tick) w_div = '0;
        else                           w_div = r_div + 1'b1;

        if (w_tick) w_bsc = w_bit_end ? '0 : r_bsc + 1'b1;

        case (r_state)
            IDLE: begin
                w_serial_out = 1'b1;
                w_busy       = 1'b0;
                // The char_sent cycle still counts as part of the finished frame.
                if (transmit_en && !r_char_sent) begin
                    w_shift      = parallel_in;
                    w_bsc        = '0;
                    w_bic        = '0;
                    w_state      = START;
                    w_serial_out = 1'b0;
                    w_busy       = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state      = DATA;
                    w_serial_out = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift = r_shift >> 1;
                    if (r_bic == BIC_LAST) begin
                        w_state      = STOP;
                        w_serial_out = 1'b1;
                    end else begin
                        w_bic        = r_bic + 1'b1;
                        w_serial_out = w_shift[0];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state     = IDLE;
                    w_busy      = 1'b0;
                    w_char_sent = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, including
    // the shift register, is cleared so a mid-frame reset leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_bsc        <= '0;
            r_bic        <= '0;
            r_shift      <= '0;
            r_serial_out <= 1'b1;
            r_busy       <= 1'b0;
            r_char_sent  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_div        <= w_div;
            r_bsc        <= w_bsc;
            r_bic        <= w_bic;
            r_shift      <= w_shift;
            r_serial_out <= w_serial_out;
            r_busy       <= w_busy;
            r_char_sent  <= w_char_sent;
        end
    end

    assign serial_out = r_serial_out;
    assign busy       = r_busy;
    assign char_sent  = r_char_sent;

endmodule
